// File: rtl/stopwatch_counter.sv
// Stopwatch time base: divides CLK to a 0.1 s tick, counts BCD M:SS.T, drives a lap-holdable display.
// Latency: live digits update on the tick edge; the display follows one edge later. RST clears everything on its edge.
// Backpressure: none. Inputs are sampled every cycle and the outputs are always valid.
module stopwatch_counter #(
    parameter int DIV = 5000000,
    parameter int PW  = 23
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RST,
    input  logic       CLKEN,
    input  logic       LAP,
    output logic [3:0] TENTHS,
    output logic [3:0] SEC_L,
    output logic [2:0] SEC_H,
    output logic [3:0] MIN,
    output logic       HOLD,
    output logic       OVF
);

    localparam logic [PW-1:0] P_MAX = PW'(DIV - 1);

    logic [PW-1:0] p;
    logic          tick;

    // live (always running) digits
    logic [3:0] t_tenths;
    logic [3:0] t_sec_l;
    logic [2:0] t_sec_h;
    logic [3:0] t_min;

    // next live digits after an optional tick
    logic [3:0] n_tenths;
    logic [3:0] n_sec_l;
    logic [2:0] n_sec_h;
    logic [3:0] n_min;
    logic       n_wrap;

    // A tick only happens on an enabled cycle with the prescaler at its terminal count
    always_comb begin
        tick = CLKEN && (p == P_MAX);
    end

    // Prescaler: runs while enabled, holds its partial tenth while paused
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p <= '0;
        end else if (RST) begin
            p <= '0;
        end else if (CLKEN) begin
            p <= tick ? '0 : p + 1'b1;
        end
    end

    // BCD cascade: each digit rolls over only when every lower digit is at its maximum
    always_comb begin
        n_tenths = t_tenths;
        n_sec_l  = t_sec_l;
        n_sec_h  = t_sec_h;
        n_min    = t_min;
        n_wrap   = 1'b0;
        if (tick) begin
            if (t_tenths != 4'd9) begin
                n_tenths = t_tenths + 4'd1;
            end else begin
                n_tenths = 4'd0;
                if (t_sec_l != 4'd9) begin
                    n_sec_l = t_sec_l + 4'd1;
                end else begin
                    n_sec_l = 4'd0;
                    if (t_sec_h != 3'd5) begin
                        n_sec_h = t_sec_h + 3'd1;
                    end else begin
                        n_sec_h = 3'd0;
                        if (t_min != 4'd9) begin
                            n_min = t_min + 4'd1;
                        end else begin
                            n_min  = 4'd0;
                            n_wrap = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Live digits and the sticky overflow flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            t_tenths <= 4'd0;
            t_sec_l  <= 4'd0;
            t_sec_h  <= 3'd0;
            t_min    <= 4'd0;
            OVF      <= 1'b0;
        end else if (RST) begin
            t_tenths <= 4'd0;
            t_sec_l  <= 4'd0;
            t_sec_h  <= 3'd0;
            t_min    <= 4'd0;
            OVF      <= 1'b0;
        end else begin
            t_tenths <= n_tenths;
            t_sec_l  <= n_sec_l;
            t_sec_h  <= n_sec_h;
            t_min    <= n_min;
            OVF      <= OVF | n_wrap;
        end
    end

    // Display copies the pre-tick live value unless frozen; LAP toggles the freeze
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TENTHS <= 4'd0;
            SEC_L  <= 4'd0;
            SEC_H  <= 3'd0;
            MIN    <= 4'd0;
            HOLD   <= 1'b0;
        end else if (RST) begin
            TENTHS <= 4'd0;
            SEC_L  <= 4'd0;
            SEC_H  <= 3'd0;
            MIN    <= 4'd0;
            HOLD   <= 1'b0;
        end else begin
            if (!HOLD) begin
                TENTHS <= t_tenths;
                SEC_L  <= t_sec_l;
                SEC_H  <= t_sec_h;
                MIN    <= t_min;
            end
            if (LAP) begin
                HOLD <= !HOLD;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (DIV=4/PW=2 and DIV=1/PW=1) against an elapsed-tenths model.
// Latency: model and DUT advance on the same edge, compared on the falling edge.
// Backpressure: none.
module tb_stopwatch_counter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // instance A: DIV=4, PW=2
    logic       a_reset = 1'b1, a_rst = 1'b0, a_en = 1'b0, a_lap = 1'b0;
    logic [3:0] a_tenths, a_sec_l, a_min;
    logic [2:0] a_sec_h;
    logic       a_hold, a_ovf;
    // instance B: DIV=1, PW=1
    logic       b_reset = 1'b1, b_rst = 1'b0, b_en = 1'b0, b_lap = 1'b0;
    logic [3:0] b_tenths, b_sec_l, b_min;
    logic [2:0] b_sec_h;
    logic       b_hold, b_ovf;

    logic [14:0] disp_a, disp_b;
    assign disp_a = {a_min, a_sec_h, a_sec_l, a_tenths};
    assign disp_b = {b_min, b_sec_h, b_sec_l, b_tenths};

    stopwatch_counter #(.DIV(4), .PW(2)) dut_a (
        .CLK(CLK), .RESET(a_reset), .RST(a_rst), .CLKEN(a_en), .LAP(a_lap),
        .TENTHS(a_tenths), .SEC_L(a_sec_l), .SEC_H(a_sec_h), .MIN(a_min),
        .HOLD(a_hold), .OVF(a_ovf)
    );

    stopwatch_counter #(.DIV(1), .PW(1)) dut_b (
        .CLK(CLK), .RESET(b_reset), .RST(b_rst), .CLKEN(b_en), .LAP(b_lap),
        .TENTHS(b_tenths), .SEC_L(b_sec_l), .SEC_H(b_sec_h), .MIN(b_min),
        .HOLD(b_hold), .OVF(b_ovf)
    );

    // model: elapsed time as an integer count of tenths (0..5999)
    int m_cnt[2]  = '{0, 0};
    int m_p[2]    = '{0, 0};
    int m_disp[2] = '{0, 0};
    bit m_hold[2] = '{1'b0, 1'b0};
    bit m_ovf[2]  = '{1'b0, 1'b0};
    int m_div[2]  = '{4, 1};

    task automatic model_clear(input int i);
        m_cnt[i]  = 0;
        m_p[i]    = 0;
        m_disp[i] = 0;
        m_hold[i] = 1'b0;
        m_ovf[i]  = 1'b0;
    endtask

    task automatic model_step(input int i, input logic r, input logic e, input logic l);
        int pre;
        bit tk;
        if (r) begin
            model_clear(i);
        end else begin
            pre = m_cnt[i];
            tk  = e && (m_p[i] == m_div[i] - 1);
            if (e) m_p[i] = tk ? 0 : m_p[i] + 1;
            if (tk) begin
                if (m_cnt[i] == 5999) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (!m_hold[i]) m_disp[i] = pre;
            if (l) m_hold[i] = !m_hold[i];
        end
    endtask

    // tenths count -> packed {MIN, SEC_H, SEC_L, TENTHS}
    function automatic logic [14:0] enc(input int v);
        logic [3:0] mn, sl, tn;
        logic [2:0] sh;
        tn = 4'(v % 10);
        sl = 4'((v / 10) % 10);
        sh = 3'((v / 100) % 6);
        mn = 4'(v / 600);
        return {mn, sh, sl, tn};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK or posedge a_reset) begin
        if (a_reset) model_clear(0);
        else model_step(0, a_rst, a_en, a_lap);
    end

    always @(posedge CLK or posedge b_reset) begin
        if (b_reset) model_clear(1);
        else model_step(1, b_rst, b_en, b_lap);
    end

    // every-cycle comparison against the model
    always @(negedge CLK) begin
        check("a_disp", disp_a, enc(m_disp[0]));
        check("a_hold", a_hold, m_hold[0]);
        check("a_ovf",  a_ovf,  m_ovf[0]);
        check("b_disp", disp_b, enc(m_disp[1]));
        check("b_hold", b_hold, m_hold[1]);
        check("b_ovf",  b_ovf,  m_ovf[1]);
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2;
        check("reset_a", {disp_a, a_hold, a_ovf}, 0);
        check("reset_b", {disp_b, b_hold, b_ovf}, 0);
        cyc; cyc;
        a_reset = 1'b0;
        b_reset = 1'b0;

        // 40 enabled cycles at DIV=4 -> 1.0 s
        a_rst = 1'b1; cyc; a_rst = 1'b0;
        a_en = 1'b1; repeat (40) cyc; a_en = 1'b0; cyc;
        check("t1_secl", a_sec_l, 1);
        check("t1_tenths", a_tenths, 0);
        check("t1_min_sech", {a_min, a_sec_h}, 0);
        check("t1_ovf", a_ovf, 0);

        // pause keeps the partial tenth
        a_rst = 1'b1; cyc; a_rst = 1'b0;
        a_en = 1'b1; repeat (6) cyc; a_en = 1'b0;
        repeat (10) begin
            cyc;
            check("t2_pause", a_tenths, 1);
        end
        a_en = 1'b1; repeat (2) cyc; a_en = 1'b0; cyc;
        check("t2_resume", a_tenths, 2);

        // full scale and wrap at DIV=1
        b_rst = 1'b1; cyc; b_rst = 1'b0;
        b_en = 1'b1; repeat (5999) cyc; b_en = 1'b0; cyc;
        check("t3_max", disp_b, {4'd9, 3'd5, 4'd9, 4'd9});
        check("t3_max_ovf", b_ovf, 0);
        b_en = 1'b1; cyc; b_en = 1'b0; cyc;
        check("t3_wrap", disp_b, 0);
        check("t3_wrap_ovf", b_ovf, 1);
        b_rst = 1'b1; cyc; b_rst = 1'b0;
        check("t3_rst_ovf", b_ovf, 0);

        // lap freeze while counting continues
        b_rst = 1'b1; cyc; b_rst = 1'b0;
        b_en = 1'b1; repeat (123) cyc;
        b_lap = 1'b1; cyc; b_lap = 1'b0;
        repeat (49) begin
            check("t4_frozen", disp_b, {4'd0, 3'd1, 4'd2, 4'd3});
            check("t4_hold", b_hold, 1);
            cyc;
        end
        check("t4_frozen_end", disp_b, {4'd0, 3'd1, 4'd2, 4'd3});
        b_lap = 1'b1; b_en = 1'b0; cyc; b_lap = 1'b0; cyc;
        check("t4_release", disp_b, {4'd0, 3'd1, 4'd7, 4'd3});
        check("t4_release_hold", b_hold, 0);

        // async RESET mid-count, then first tick on the 4th edge
        a_rst = 1'b1; cyc; a_rst = 1'b0;
        a_en = 1'b1; repeat (120) cyc; cyc;
        check("t5_count", {a_sec_l, a_tenths}, {4'd3, 4'd0});
        #3 a_reset = 1'b1;
        #1 check("t5_async", {disp_a, a_hold, a_ovf}, 0);
        cyc;
        a_reset = 1'b0;
        repeat (4) cyc;
        check("t5_tick4_pre", a_tenths, 0);
        cyc;
        check("t5_tick4", a_tenths, 1);
        a_en = 1'b0;

        // RST beats LAP; LAP works while stopped
        b_en = 1'b1; repeat (20) cyc; b_en = 1'b0; cyc;
        b_rst = 1'b1; b_lap = 1'b1; cyc; b_rst = 1'b0; b_lap = 1'b0;
        check("t6_rstlap_hold", b_hold, 0);
        check("t6_rstlap_disp", disp_b, 0);
        b_en = 1'b1; repeat (7) cyc; b_en = 1'b0; cyc;
        b_lap = 1'b1; cyc; b_lap = 1'b0;
        check("t6_stopped_lap_hold", b_hold, 1);
        check("t6_stopped_lap_val", b_tenths, 7);
        b_en = 1'b1; repeat (5) cyc; b_en = 1'b0;
        check("t6_still_frozen", b_tenths, 7);
        b_lap = 1'b1; cyc; b_lap = 1'b0; cyc;
        check("t6_unfrozen", disp_b, {4'd0, 3'd0, 4'd1, 4'd2});

        // randomized traffic on both instances
        repeat (3000) begin
            a_en    = ($urandom_range(0, 3) != 0);
            a_lap   = ($urandom_range(0, 24) == 0);
            a_rst   = ($urandom_range(0, 299) == 0);
            a_reset = ($urandom_range(0, 699) == 0);
            b_en    = ($urandom_range(0, 3) != 0);
            b_lap   = ($urandom_range(0, 24) == 0);
            b_rst   = ($urandom_range(0, 299) == 0);
            b_reset = ($urandom_range(0, 699) == 0);
            cyc;
        end
        a_en = 1'b0; a_lap = 1'b0; a_rst = 1'b0; a_reset = 1'b0;
        b_en = 1'b0; b_lap = 1'b0; b_rst = 1'b0; b_reset = 1'b0;
        cyc; cyc;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping datapath of the stopwatch. It consumes the registered `CLKEN`/`RST` pair from the stopwatch control state machine and divides `CLK` down to a 0.1 s tick. It accumulates elapsed time as BCD digits (M:SS.T, up to 9:59.9) and presents a registered display value with lap-hold capability to the display driver.

## Interface
- `DIV`, 5000000: `CLK` cycles per 0.1 s tick while enabled (50 MHz -> 10 Hz); legal range 1..2^`PW`.
- `PW`, 23: prescaler counter width.
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `RST`  in  1  synchronous clear from the control state machine; one-cycle pulse, level also honoured.
- `CLKEN`  in  1  count enable from the control state machine; high for the whole counting interval.
- `LAP`  in  1  single-cycle pulse (pre-debounced) that toggles lap hold.
- `TENTHS`  out  4  displayed tenths digit, BCD 0-9.
- `SEC_L`  out  4  displayed seconds units digit, BCD 0-9.
- `SEC_H`  out  3  displayed seconds tens digit, 0-5.
- `MIN`  out  4  displayed minutes digit, BCD 0-9.
- `HOLD`  out  1  high while the display is frozen by lap.
- `OVF`  out  1  sticky flag: elapsed time wrapped past 9:59.9.

## Operation
- Internal state: prescaler `P[PW-1:0]`, live digits `T` (tenths/secL/secH/min), display registers `D`, `HOLD`, `OVF`.
- Priority per cycle: `RST` > `CLKEN`/`LAP`. When `RST`=1, `P`, `T`, `D`, `HOLD`, and `OVF` are all cleared, and `CLKEN`/`LAP` are ignored that cycle.
- Prescaler:
  - When `CLKEN`=1: if `P`==`DIV`-1, then `P`<=0 and a tick is issued; otherwise `P`<=`P`+1.
  - When `CLKEN`=0: `P` holds. The partial tenth is preserved across pause and resume and is lost only on `RST`.
- Tick increments `T` as a BCD cascade:
  - tenths 9->0 carries into secL;
  - secL 9->0 carries into secH;
  - secH 5->0 carries into min;
  - min 9->0 wraps the whole value to 0:00.0 and sets `OVF`=1. `OVF` stays set until `RST` or `RESET`.
- No digit ever holds a non-BCD value. `SEC_H` never exceeds 5.
- Display:
  - When `HOLD`=0, `D`<=`T` every cycle.
  - When `HOLD`=1, `D` holds. `T` keeps counting underneath.
- `LAP` with `HOLD`=0: sets `HOLD`=1 and loads `D`<=`T`, using the pre-tick value if a tick occurs in the same cycle.
- `LAP` with `HOLD`=1: clears `HOLD`. `D` resumes tracking on the following edge.
- `LAP` is accepted regardless of `CLKEN`, so a frozen lap can be held across stop and start.

## Timing
- `RESET` asserted: all outputs go to 0 immediately (`TENTHS`=`SEC_L`=`SEC_H`=`MIN`=0, `HOLD`=0, `OVF`=0). Registers stay cleared until the first edge after deassertion. `RESET` mid-count discards all state.
- Tick latency:
  - The first tick occurs on the `DIV`th rising edge with `CLKEN`=1 after a clear.
  - `T` updates on that edge.
  - Display outputs reflect it one edge later (registered `D`, 1-cycle lag).
- `RST` latency: `T` is 0 after the `RST` edge, and the outputs are 0 on the same edge because `D` is cleared directly.
- `DIV`=1: every enabled cycle is a tick. This is legal and used for simulation.
- `CLKEN` deasserted in the same cycle `P` would reach `DIV`-1: no tick occurs, and `P` holds at `DIV`-1, so the tick fires on the first re-enabled edge.
- Simultaneous `LAP` and wrap: `D` captures 9:59.9, `HOLD`=1, `T`=0:00.0, `OVF`=1.

## Test plan
- `DIV`=4, pulse `RST`, then `CLKEN`=1 for 40 cycles -> after 1 more edge: `MIN`=0, `SEC_H`=0, `SEC_L`=1, `TENTHS`=0, `OVF`=0.
- `DIV`=4, `CLKEN` high for 6 cycles, low for 10, high for 2 -> `TENTHS`=2. Check that `TENTHS`=1 throughout the low window, confirming the prescaler holds.
- `DIV`=1, `CLKEN` high for 5999 cycles -> display 9:59.9 (`MIN`=9, `SEC_H`=5, `SEC_L`=9, `TENTHS`=9), `OVF`=0. One more enabled cycle -> 0:00.0, `OVF`=1. `RST` -> `OVF`=0.
- `DIV`=1, count to 0:12.3, pulse `LAP` -> `HOLD`=1 and the display frozen at 0:12.3 while counting continues 50 cycles. Pulse `LAP` again -> `HOLD`=0 and the display shows 0:17.3, two edges later at the latest.
- `DIV`=4, count to 0:03.0, then assert `RESET` asynchronously mid-cycle -> all outputs 0 before the next edge. After release, with `CLKEN` still high, the first tick arrives on the 4th edge.
- `RST` and `LAP` in the same cycle while `HOLD`=0 -> `HOLD` stays 0 and all digits are 0. `CLKEN`=0 plus a `LAP` pulse -> `HOLD`=1 with the frozen value.
